ex_mem_stage: RTL and testbench

Parametrised EX→MEM pipeline boundary with a valid/ready handshake, a two-entry skid buffer, synchronous flush, and memory-access qualification. The skid buffer gives a registered upstream `ex_ready`. At capture the block computes the byte-enable mask and a misalignment flag, and it exposes the held destination register for the hazard/forwarding unit. It sits between the execute-stage ALU and the data-memory interface, replacing the fixed-width, always-enabled EX/MEM register.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipe_skid.sv | 46 ++++
 rtl/ex_mem_stage.sv | 91 +++++++++
 tb/tb_ex_mem_stage.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared transfer-size codes and the EX/MEM beat payload.
package pipe_pkg;
  localparam int MAX_XLEN = 64;
  localparam int MAX_AW_W = 5;
  localparam int MAX_XFER_W = 4;
  localparam int MAX_BE_W = MAX_XLEN / 8;
  typedef enum logic [MAX_XFER_W-1:0] {
    XFER_B = 4'd1,
    XFER_H = 4'd2,
    XFER_W = 4'd4,
    XFER_D = 4'd8
  } xfer_size_e;
  typedef struct packed {
    logic                  mem2reg;
    logic                  reg_write;
    logic                  mem_write;
    logic                  mem_read;
    logic [MAX_XFER_W-1:0] xfer_size;
    logic [MAX_AW_W-1:0]   aw;
    logic [MAX_XLEN-1:0]   db;
    logic [MAX_XLEN-1:0]   alu_out;
    logic [MAX_BE_W-1:0]   byte_en;
    logic                  misaligned;
  } exmem_payload_t;
  function automatic logic size_legal(input logic [7:0] s);
    return s == 8'(XFER_B) || s == 8'(XFER_H) || s == 8'(XFER_W) || s == 8'(XFER_D);
  endfunction
endpackage

// File: rtl/pipe_skid.sv
// pipe_skid: two-entry skid buffer with flush; ready depends only on the skid flop.
module pipe_skid #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  input  logic flush,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);
  logic main_v, skid_v, in_xfer, out_xfer;
  T main_d, skid_d;
  assign in_ready = !skid_v;
  assign in_xfer = in_valid & !skid_v;
  assign out_xfer = main_v & out_ready;
  assign out_valid = main_v;
  assign out_data = main_d;
  // skid only fills while main is stalled, so with skid full no input can be accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || out_xfer) begin
      if (skid_v) begin
        main_d <= skid_d;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        main_v <= in_xfer;
        if (in_xfer) main_d <= in_data;
      end
    end else if (in_xfer) begin
      skid_v <= 1'b1;
      skid_d <= in_data;
    end
  end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM boundary with skid buffering, access qualification and stall counting.
module ex_mem_stage #(
  parameter int XLEN   = 64,
  parameter int AW_W   = 5,
  parameter int XFER_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic                ex_mem2reg,
  input  logic                ex_reg_write,
  input  logic                ex_mem_write,
  input  logic                ex_mem_read,
  input  logic [XFER_W-1:0]   ex_xfer_size,
  input  logic [AW_W-1:0]     ex_aw,
  input  logic [XLEN-1:0]     ex_db,
  input  logic [XLEN-1:0]     ex_alu_out,
  input  logic                flush,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_mem2reg,
  output logic                mem_reg_write,
  output logic                mem_mem_write,
  output logic                mem_mem_read,
  output logic [XFER_W-1:0]   mem_xfer_size,
  output logic [AW_W-1:0]     mem_aw,
  output logic [XLEN-1:0]     mem_db,
  output logic [XLEN-1:0]     mem_alu_out,
  output logic [XLEN/8-1:0]   mem_byte_en,
  output logic                mem_misaligned,
  output logic                fwd_valid,
  output logic [AW_W-1:0]     fwd_aw,
  output logic [XLEN-1:0]     fwd_data,
  output logic [CNT_W-1:0]    stall_cnt
);
  import pipe_pkg::*;
  localparam int BE_W = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  logic mem_op, mis;
  logic [7:0] sz, off;
  logic [15:0] be;
  exmem_payload_t d, q;
  always_comb begin
    sz = 8'(ex_xfer_size);
    off = 8'(ex_alu_out[OFF_W-1:0]);
    mem_op = ex_mem_read | ex_mem_write;
    mis = mem_op & (!size_legal(sz) | (|(off & (sz - 8'd1))) | (off + sz > 8'(BE_W)));
    be = (mem_op & !mis) ? ((16'd1 << sz) - 16'd1) << off : 16'd0;
    d = '0;
    d.mem2reg = ex_mem2reg;
    d.reg_write = ex_reg_write;
    d.mem_write = ex_mem_write & !mis;
    d.mem_read = ex_mem_read & !mis;
    d.xfer_size = MAX_XFER_W'(ex_xfer_size);
    d.aw = MAX_AW_W'(ex_aw);
    d.db = MAX_XLEN'(ex_db);
    d.alu_out = MAX_XLEN'(ex_alu_out);
    d.byte_en = MAX_BE_W'(be);
    d.misaligned = mis;
  end
  pipe_skid #(.T(exmem_payload_t)) u_skid (
    .clk(clk),
    .reset(reset),
    .in_valid(ex_valid),
    .in_ready(ex_ready),
    .in_data(d),
    .flush(flush),
    .out_valid(mem_valid),
    .out_ready(mem_ready),
    .out_data(q)
  );
  assign mem_mem2reg = q.mem2reg;
  assign mem_reg_write = q.reg_write;
  assign mem_mem_write = q.mem_write;
  assign mem_mem_read = q.mem_read;
  assign mem_xfer_size = q.xfer_size[XFER_W-1:0];
  assign mem_aw = q.aw[AW_W-1:0];
  assign mem_db = q.db[XLEN-1:0];
  assign mem_alu_out = q.alu_out[XLEN-1:0];
  assign mem_byte_en = q.byte_en[BE_W-1:0];
  assign mem_misaligned = q.misaligned;
  assign fwd_valid = mem_valid & q.reg_write;
  assign fwd_aw = mem_aw;
  assign fwd_data = mem_alu_out;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt <= '0;
    else if (mem_valid && !mem_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed checks of qualification, backpressure, flush, reset and counter saturation.
module tb_ex_mem_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ex_valid = 1'b0, ex_ready;
  logic ex_mem2reg = 1'b0, ex_reg_write = 1'b0, ex_mem_write = 1'b0, ex_mem_read = 1'b0;
  logic [3:0] ex_xfer_size = '0;
  logic [4:0] ex_aw = '0;
  logic [63:0] ex_db = '0, ex_alu_out = '0;
  logic flush = 1'b0;
  logic mem_valid, mem_ready = 1'b0;
  logic mem_mem2reg, mem_reg_write, mem_mem_write, mem_mem_read;
  logic [3:0] mem_xfer_size;
  logic [4:0] mem_aw, fwd_aw;
  logic [63:0] mem_db, mem_alu_out, fwd_data;
  logic [7:0] mem_byte_en;
  logic mem_misaligned, fwd_valid;
  logic [3:0] stall_cnt;
  int errors = 0, checks = 0;
  ex_mem_stage #(.XLEN(64), .AW_W(5), .XFER_W(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_mem2reg(ex_mem2reg), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_mem_read(ex_mem_read), .ex_xfer_size(ex_xfer_size), .ex_aw(ex_aw), .ex_db(ex_db),
    .ex_alu_out(ex_alu_out), .flush(flush), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_mem2reg(mem_mem2reg), .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
    .mem_mem_read(mem_mem_read), .mem_xfer_size(mem_xfer_size), .mem_aw(mem_aw),
    .mem_db(mem_db), .mem_alu_out(mem_alu_out), .mem_byte_en(mem_byte_en),
    .mem_misaligned(mem_misaligned), .fwd_valid(fwd_valid), .fwd_aw(fwd_aw),
    .fwd_data(fwd_data), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [63:0] alu, input logic [3:0] sz, input logic rd,
                      input logic wr, input logic rw, input logic [4:0] aw);
    ex_valid = 1'b1;
    ex_alu_out = alu;
    ex_xfer_size = sz;
    ex_mem_read = rd;
    ex_mem_write = wr;
    ex_reg_write = rw;
    ex_mem2reg = rd;
    ex_aw = aw;
    ex_db = ~alu;
  endtask
  initial begin
    #12;
    chk("rst_valid", mem_valid, 0);
    chk("rst_ready", ex_ready, 1);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_be", mem_byte_en, 0);
    reset = 1'b1;
    mem_ready = 1'b1;
    beat(64'h1004, 4'd4, 1, 0, 1, 5'd1);
    step();
    chk("ld_valid", mem_valid, 1);
    chk("ld_be", mem_byte_en, 8'hF0);
    chk("ld_mis", mem_misaligned, 0);
    chk("ld_rd", mem_mem_read, 1);
    chk("ld_fwd_valid", fwd_valid, 1);
    chk("ld_fwd_aw", fwd_aw, 5'd1);
    chk("ld_fwd_data", fwd_data, 64'h1004);
    chk("ld_db", mem_db, ~64'h1004);
    beat(64'h1003, 4'd2, 0, 1, 0, 5'd2);
    step();
    chk("st_mis", mem_misaligned, 1);
    chk("st_wr", mem_mem_write, 0);
    chk("st_be", mem_byte_en, 0);
    chk("st_alu", mem_alu_out, 64'h1003);
    chk("st_fwd_valid", fwd_valid, 0);
    beat(64'h1000, 4'd3, 1, 0, 1, 5'd3);
    step();
    chk("ill_mis", mem_misaligned, 1);
    chk("ill_rd", mem_mem_read, 0);
    chk("ill_size", mem_xfer_size, 4'd3);
    beat(64'h1006, 4'd4, 0, 0, 1, 5'd4);
    step();
    chk("nomem_mis", mem_misaligned, 0);
    chk("nomem_be", mem_byte_en, 0);
    beat(64'h1000, 4'd8, 0, 1, 0, 5'd5);
    step();
    chk("dw_be", mem_byte_en, 8'hFF);
    chk("dw_wr", mem_mem_write, 1);
    ex_valid = 1'b0;
    step();
    chk("drain_valid", mem_valid, 0);
    chk("cnt0", stall_cnt, 0);
    mem_ready = 1'b0;
    beat(64'hA0, 4'd8, 1, 0, 1, 5'd6);
    step();
    chk("bp_a", mem_alu_out, 64'hA0);
    chk("bp_ready1", ex_ready, 1);
    beat(64'hB0, 4'd8, 1, 0, 1, 5'd7);
    step();
    chk("bp_ready_drop", ex_ready, 0);
    chk("bp_cnt1", stall_cnt, 1);
    chk("bp_hold_a", mem_alu_out, 64'hA0);
    beat(64'hC0, 4'd8, 1, 0, 1, 5'd8);
    step();
    chk("bp_cnt2", stall_cnt, 2);
    step();
    chk("bp_cnt3", stall_cnt, 3);
    chk("bp_still_a", mem_alu_out, 64'hA0);
    mem_ready = 1'b1;
    step();
    chk("ord_b", mem_alu_out, 64'hB0);
    chk("ord_ready", ex_ready, 1);
    step();
    chk("ord_c", mem_alu_out, 64'hC0);
    chk("ord_c_aw", mem_aw, 5'd8);
    ex_valid = 1'b0;
    step();
    chk("ord_empty", mem_valid, 0);
    chk("ord_cnt", stall_cnt, 3);
    mem_ready = 1'b0;
    beat(64'hD0, 4'd8, 1, 0, 1, 5'd9);
    step();
    beat(64'hE0, 4'd8, 1, 0, 1, 5'd10);
    step();
    chk("fl_full", ex_ready, 0);
    beat(64'hF0, 4'd8, 1, 0, 1, 5'd11);
    flush = 1'b1;
    step();
    chk("fl_valid", mem_valid, 0);
    chk("fl_ready", ex_ready, 1);
    chk("fl_cnt", stall_cnt, 5);
    flush = 1'b0;
    mem_ready = 1'b1;
    beat(64'h70, 4'd8, 1, 0, 1, 5'd12);
    step();
    chk("fl_next", mem_alu_out, 64'h70);
    chk("fl_next_valid", mem_valid, 1);
    ex_valid = 1'b0;
    step();
    chk("fl_alone", mem_valid, 0);
    mem_ready = 1'b0;
    beat(64'h80, 4'd8, 1, 0, 1, 5'd13);
    step();
    beat(64'h90, 4'd8, 1, 0, 1, 5'd14);
    step();
    ex_valid = 1'b0;
    step();
    chk("ar_pre_cnt", stall_cnt, 7);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", mem_valid, 0);
    chk("ar_ready", ex_ready, 1);
    chk("ar_cnt", stall_cnt, 0);
    chk("ar_alu", mem_alu_out, 0);
    chk("ar_be", mem_byte_en, 0);
    #2;
    reset = 1'b1;
    step();
    chk("ar_after", mem_valid, 0);
    beat(64'h1008, 4'd8, 1, 0, 1, 5'd15);
    step();
    ex_valid = 1'b0;
    chk("sat_cnt0", stall_cnt, 0);
    repeat (14) step();
    chk("sat_cnt14", stall_cnt, 14);
    repeat (6) step();
    chk("sat_cnt15", stall_cnt, 15);
    mem_ready = 1'b1;
    step();
    chk("sat_drain", mem_valid, 0);
    chk("sat_hold", stall_cnt, 15);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
